fetch_unit: RTL and testbench

Instruction fetch stage between the program counter and decode. Each cycle it can issue a word-addressed read for the address supplied by the pc stage and tell the pc stage when that address was accepted so it may advance. It tracks one outstanding memory read and buffers returned instructions, tagged with their PC, in a small FIFO toward decode. A redirect (branch taken or jump) flushes the buffer and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_inst_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffered
// instruction entries and the default buffer depth.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int FETCH_DEPTH_DEF = 2;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Circular instruction buffer between fetch and decode. Pointers wrap
// naturally because DEPTH is a power of two.
module inst_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [63:0]
) (
  input  logic   clk,
  input  logic   clr_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  entry_t        mem_q [DEPTH];
  logic          do_pop;

  assign full   = (count_q == (PW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign do_pop = pop & ~empty;
  assign head   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // The fetch FSM reserves a slot before requesting, so overflow is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!clr_n) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one word read at a time, tracks the outstanding
// response and buffers PC-tagged instructions toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] fetch_pc,
  output logic        pc_advance,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pend_pc_p0;
  logic         push;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign imem_addr  = fetch_pc;
  assign push_entry = '{inst: imem_rdata, pc: pend_pc_p0};

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    // A request from IDLE never has a slot reserved, so a free slot suffices.
    imem_req   = clr_n & (state_q == IDLE) & ~redirect & ~fifo_full;
    pc_advance = imem_req & imem_gnt;
    case (state_q)
      IDLE: begin
        if (pc_advance) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = ~redirect;
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      pend_pc_p0 <= '0;
    end else begin
      state_q <= state_d;
      if (pc_advance) pend_pc_p0 <= fetch_pc;
    end
  end

  inst_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .pop   (inst_valid & inst_ready),
    .flush (redirect),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_entry)
  );

  assign inst_valid = ~fifo_empty;
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized memory/pc/decode environment checked against a queue model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] fetch_pc;
  logic        pc_advance;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .fetch_pc    (fetch_pc),
    .pc_advance  (pc_advance),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of {inst, pc} plus "a read is outstanding" and
  // "its data must be thrown away" flags.
  logic [63:0] m_q[$];
  bit          m_out;
  bit          m_drop;
  bit          m_init;
  logic [31:0] m_pend;
  bit          exp_req;

  always @(negedge clk) begin
    exp_req = clr_n && !m_out && !redirect && (m_q.size() < DEPTH);
    if (m_init) begin
      chk("m_imem_req", imem_req, exp_req);
      chk("m_pc_advance", pc_advance, exp_req && imem_gnt);
      if (exp_req) chk("m_imem_addr", imem_addr, fetch_pc);
      chk("m_inst_valid", inst_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("m_inst", inst, m_q[0][63:32]);
        chk("m_inst_pc", inst_pc, m_q[0][31:0]);
      end
    end
    if (!clr_n) begin
      m_q.delete();
      m_out  = 1'b0;
      m_drop = 1'b0;
      m_pend = '0;
      m_init = 1'b1;
    end else begin
      if (redirect) m_q.delete();
      else if (inst_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_drop && !redirect) m_q.push_back({imem_rdata, m_pend});
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (m_out && redirect) begin
        m_drop = 1'b1;
      end
      if (exp_req && imem_gnt) begin
        m_out  = 1'b1;
        m_drop = 1'b0;
        m_pend = fetch_pc;
      end
    end
  end

  task automatic do_reset();
    clr_n       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    step();
    clr_n = 1'b1;
  endtask

  bit          acc;
  bit          pend;
  int          dly;
  logic [31:0] acc_pc;

  initial begin
    clr_n = 1'b0; redirect = 1'b0; fetch_pc = 32'h10; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

    // Reset values, then a single zero-wait fetch
    step();
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_adv", pc_advance, 0);
    step();
    clr_n = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; fetch_pc = 32'h10;
    @(negedge clk);
    chk("t1_adv", pc_advance, 1);
    chk("t1_addr", imem_addr, 32'h10);
    step();
    fetch_pc = 32'h11; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0010;
    @(negedge clk);
    chk("t1_adv_once", pc_advance, 0);
    chk("t1_not_yet", inst_valid, 0);
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t1_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'hDEAD0010);
    chk("t1_pc", inst_pc, 32'h10);
    step();
    @(negedge clk);
    chk("t1_drained", inst_valid, 0);

    // Buffer fills with decode stalled, then drains in order
    do_reset();
    fetch_pc = 32'h10; imem_gnt = 1'b1;
    step();
    fetch_pc = 32'h11; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0010;
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t2_req2", imem_req, 1);
    chk("t2_addr2", imem_addr, 32'h11);
    step();
    fetch_pc = 32'h12; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0011;
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t2_full_req", imem_req, 0);
    chk("t2_head_pc", inst_pc, 32'h10);
    step();
    @(negedge clk);
    chk("t2_full_req_hold", imem_req, 0);
    step();
    inst_ready = 1'b1; imem_gnt = 1'b0;
    @(negedge clk);
    chk("t2_pop0_pc", inst_pc, 32'h10);
    chk("t2_pop0_inst", inst, 32'hDEAD0010);
    chk("t2_req_while_full", imem_req, 0);
    step();
    @(negedge clk);
    chk("t2_pop1_pc", inst_pc, 32'h11);
    chk("t2_pop1_inst", inst, 32'hDEAD0011);
    chk("t2_req_resume", imem_req, 1);
    chk("t2_addr3", imem_addr, 32'h12);
    step();
    @(negedge clk);
    chk("t2_empty", inst_valid, 0);

    // Redirect while a read is outstanding; late 0xBAD is discarded
    do_reset();
    fetch_pc = 32'h20; imem_gnt = 1'b1; inst_ready = 1'b1;
    step();
    imem_gnt = 1'b0; redirect = 1'b1; fetch_pc = 32'h40;
    @(negedge clk);
    chk("t3_req_redir", imem_req, 0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_drop_req", imem_req, 0);
    step();
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
    @(negedge clk);
    chk("t3_drop_resp_req", imem_req, 0);
    step();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    chk("t3_nopush", inst_valid, 0);
    chk("t3_adv", pc_advance, 1);
    chk("t3_addr", imem_addr, 32'h40);
    step();
    imem_gnt = 1'b0; fetch_pc = 32'h41; imem_rvalid = 1'b1; imem_rdata = 32'h4040;
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t3_valid", inst_valid, 1);
    chk("t3_pc", inst_pc, 32'h40);
    chk("t3_inst", inst, 32'h4040);
    step();

    // Redirect coincident with rvalid and a pop
    do_reset();
    fetch_pc = 32'h10; imem_gnt = 1'b1;
    step();
    fetch_pc = 32'h11; imem_rvalid = 1'b1; imem_rdata = 32'hA0;
    step();
    imem_rvalid = 1'b0;
    step();
    imem_gnt = 1'b0; fetch_pc = 32'h12; redirect = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hA1; inst_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_before", inst_valid, 1);
    step();
    redirect = 1'b0; imem_rvalid = 1'b0; fetch_pc = 32'h80;
    @(negedge clk);
    chk("t4_empty", inst_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h80);
    step();
    @(negedge clk);
    chk("t4_empty2", inst_valid, 0);

    // Reset while waiting; the stray response afterwards is ignored
    do_reset();
    fetch_pc = 32'h30; imem_gnt = 1'b1;
    step();
    clr_n = 1'b0; imem_gnt = 1'b0;
    step();
    clr_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h5555;
    @(negedge clk);
    chk("t5_valid", inst_valid, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 32'h30);
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t5_valid2", inst_valid, 0);

    // Grant withheld for four cycles
    do_reset();
    fetch_pc = 32'h77; imem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_req_held", imem_req, 1);
      chk("t6_addr_stable", imem_addr, 32'h77);
      chk("t6_no_adv", pc_advance, 0);
      step();
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("t6_adv", pc_advance, 1);
    step();
    imem_gnt = 1'b0;

    // Randomized environment
    do_reset();
    pend = 1'b0;
    dly  = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      acc    = imem_req && imem_gnt;
      acc_pc = fetch_pc;
      step();
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      clr_n       = 1'b1;
      if (acc) begin
        pend     = 1'b1;
        dly      = $urandom_range(0, 3);
        fetch_pc = acc_pc + 32'd1;
      end
      if (pend && dly == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
        pend        = 1'b0;
      end else if (pend) begin
        dly--;
      end else if ($urandom_range(0, 29) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
      if ($urandom_range(0, 9) == 0) begin
        redirect = 1'b1;
        fetch_pc = $urandom;
      end
      imem_gnt   = ($urandom_range(0, 9) < 7);
      inst_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 199) == 0) clr_n = 1'b0;
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
